round_judge_engine: RTL and testbench

Parametrised per-round game engine for the reaction game: accepts an instruction (target key, optionally inverted "NOT" form) and waits for the player's key press. It judges the press on release, or flags a timeout, then holds a feedback window. It keeps a saturating score and a lives counter and declares game-over. It sits between the instruction source and the VGA/HEX front ends, which read its status outputs.

---
 rtl/round_judge_if.sv | 38 +++
 rtl/round_judge_engine.sv | 164 ++++++++++++++++
 tb/tb_round_judge_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/round_judge_if.sv
// Bus between the reaction-game engine and its surroundings: the instruction
// handshake, the key levels and the status read by the display front ends.
interface round_judge_if #(
  parameter int N_CH    = 6,
  parameter int SCORE_W = 8,
  parameter int LIVES   = 3
);
  localparam int TW = $clog2(N_CH);
  localparam int LW = $clog2(LIVES + 1);

  logic               start;
  logic [N_CH-1:0]    user_input;
  logic [TW-1:0]      ins_target;
  logic               ins_invert;
  logic               ins_valid;
  logic               ins_ready;
  logic               round_correct;
  logic               round_wrong;
  logic               timeout;
  logic [SCORE_W-1:0] score;
  logic [LW-1:0]      lives;
  logic               dead;
  logic [2:0]         state;

  // Instruction source / player side
  modport master (
    output start, user_input, ins_target, ins_invert, ins_valid,
    input  ins_ready, round_correct, round_wrong, timeout,
           score, lives, dead, state
  );

  // Engine side
  modport slave (
    input  start, user_input, ins_target, ins_invert, ins_valid,
    output ins_ready, round_correct, round_wrong, timeout,
           score, lives, dead, state
  );
endinterface

// File: rtl/round_judge_engine.sv
// Per-round engine of the reaction game: accepts an instruction, waits for a
// key press, judges it on release (or flags a timeout), holds a feedback
// window, and tracks a saturating score, remaining lives and game-over.
module round_judge_engine #(
  parameter int N_CH     = 6,
  parameter int TIMEOUT  = 150000000,
  parameter int FEEDBACK = 50000000,
  parameter int LIVES    = 3,
  parameter int SCORE_W  = 8,
  parameter int CNT_W    = 28
) (
  input  logic         clk,
  input  logic         reset,
  round_judge_if.slave bus
);
  localparam int TW = $clog2(N_CH);
  localparam int LW = $clog2(LIVES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FB_LAST = CNT_W'(FEEDBACK - 1);
  localparam logic [LW-1:0]    LV_INIT = LW'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ARM          = 3'd1,
    S_WAIT_PRESS   = 3'd2,
    S_WAIT_RELEASE = 3'd3,
    S_FEEDBACK     = 3'd4,
    S_DEAD         = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [TW-1:0]      r_target, w_target_nxt;
  logic               r_invert, w_invert_nxt;
  logic [N_CH-1:0]    r_press, w_press_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [LW-1:0]      r_lives, w_lives_nxt;
  logic               r_correct, w_correct_nxt;
  logic               r_wrong, w_wrong_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               w_ready;
  logic               w_hit;
  logic               w_onehot;
  logic               w_judge_ok;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

  function automatic logic [LW-1:0] floor_dec(input logic [LW-1:0] l);
    return (l == '0) ? l : l - 1'b1;
  endfunction

  // A key still held from the previous round blocks a new instruction
  assign w_ready = (r_state == S_ARM) && (bus.user_input == '0);

  // Judge the latched press: single key, and it must (or must not) be the target
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_target == i[TW-1:0]) w_hit = r_press[i];
    end
    w_onehot   = (r_press != '0) && ((r_press & (r_press - 1'b1)) == '0);
    w_judge_ok = w_onehot && (r_invert ? !w_hit : w_hit);
  end

  // Next-state and next-value decode for the round sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_target_nxt  = r_target;
    w_invert_nxt  = r_invert;
    w_press_nxt   = r_press;
    w_score_nxt   = r_score;
    w_lives_nxt   = r_lives;
    w_correct_nxt = 1'b0;
    w_wrong_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_DEAD: begin
        if (bus.start) begin
          w_state_nxt = S_ARM;
          w_score_nxt = '0;
          w_lives_nxt = LV_INIT;
        end
      end
      S_ARM: begin
        if (bus.ins_valid && w_ready) begin
          w_target_nxt = bus.ins_target;
          w_invert_nxt = bus.ins_invert;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_WAIT_PRESS;
        end
      end
      S_WAIT_PRESS: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // A press on the final cycle still beats the timeout
        if (bus.user_input != '0) begin
          w_press_nxt = bus.user_input;
          w_state_nxt = S_WAIT_RELEASE;
        end else if (r_cnt == TO_LAST) begin
          w_timeout_nxt = 1'b1;
          w_wrong_nxt   = 1'b1;
          w_lives_nxt   = floor_dec(r_lives);
          w_cnt_nxt     = '0;
          w_state_nxt   = S_FEEDBACK;
        end
      end
      S_WAIT_RELEASE: begin
        if (bus.user_input == '0) begin
          w_correct_nxt = w_judge_ok;
          w_wrong_nxt   = !w_judge_ok;
          if (w_judge_ok) w_score_nxt = sat_inc(r_score);
          else            w_lives_nxt = floor_dec(r_lives);
          w_cnt_nxt   = '0;
          w_state_nxt = S_FEEDBACK;
        end
      end
      S_FEEDBACK: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == FB_LAST) begin
          w_state_nxt = (r_lives == '0) ? S_DEAD : S_ARM;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter, latched round data, score/lives and result pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_target  <= '0;
      r_invert  <= 1'b0;
      r_press   <= '0;
      r_score   <= '0;
      r_lives   <= LV_INIT;
      r_correct <= 1'b0;
      r_wrong   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_target  <= w_target_nxt;
      r_invert  <= w_invert_nxt;
      r_press   <= w_press_nxt;
      r_score   <= w_score_nxt;
      r_lives   <= w_lives_nxt;
      r_correct <= w_correct_nxt;
      r_wrong   <= w_wrong_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.ins_ready     = w_ready;
  assign bus.round_correct = r_correct;
  assign bus.round_wrong   = r_wrong;
  assign bus.timeout       = r_timeout;
  assign bus.score         = r_score;
  assign bus.lives         = r_lives;
  assign bus.dead          = (r_state == S_DEAD);
  assign bus.state         = r_state;
endmodule

// File: tb/tb_round_judge_engine.sv
// Randomized bench for round_judge_engine: rounds are described by target,
// invert, press vector, press delay and hold length; the expected outcome,
// score, lives and timing are derived from the game rules.
module tb_round_judge_engine;
  localparam int N_CH     = 6;
  localparam int TIMEOUT  = 8;
  localparam int FEEDBACK = 4;
  localparam int LIVES    = 2;
  localparam int SCORE_W  = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_score;
  int   m_lives;

  round_judge_if #(.N_CH(N_CH), .SCORE_W(SCORE_W), .LIVES(LIVES)) bus ();

  round_judge_engine #(
    .N_CH(N_CH), .TIMEOUT(TIMEOUT), .FEEDBACK(FEEDBACK),
    .LIVES(LIVES), .SCORE_W(SCORE_W), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_score = 0;
    m_lives = LIVES;
    check_val("start_state", bus.state, 1);
    check_val("start_score", bus.score, 0);
    check_val("start_lives", bus.lives, LIVES);
    check_val("start_dead", bus.dead, 0);
  endtask

  // One full round from ARM; pv==0 means the player never presses
  task automatic play_round(input int tgt, input bit inv, input logic [N_CH-1:0] pv,
                            input int d, input int h, input bit carry);
    bit exp_ok;
    bit exp_to;
    int k;
    int nxt;
    bus.ins_target = 3'(tgt);
    bus.ins_invert = inv;
    bus.ins_valid  = 1'b1;
    #1;
    check_val("arm_ready", bus.ins_ready, 1);
    tick();
    bus.ins_valid = 1'b0;
    check_val("accept_state", bus.state, 2);
    exp_to = (pv == '0);
    if (exp_to) begin
      repeat (TIMEOUT - 1) tick();
      check_val("to_last_cycle_state", bus.state, 2);
      check_val("to_not_early", bus.timeout, 0);
      tick();
    end else begin
      repeat (d) tick();
      bus.user_input = pv;
      tick();
      check_val("latched_state", bus.state, 3);
      repeat (h - 1) begin
        bus.user_input = pv | (($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63)) : 6'd0);
        tick();
      end
      bus.user_input = '0;
      tick();
    end
    k = -1;
    for (int i = 0; i < N_CH; i++) if (pv[i]) k = i;
    exp_ok = !exp_to && ($countones(pv) == 1) && (inv ? (k != tgt) : (k == tgt));
    if (exp_ok) m_score = (m_score + 1 > 3) ? 3 : m_score + 1;
    else        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    check_val("fb_state", bus.state, 4);
    check_val("pulse_correct", bus.round_correct, exp_ok);
    check_val("pulse_wrong", bus.round_wrong, !exp_ok);
    check_val("pulse_timeout", bus.timeout, exp_to);
    check_val("score", bus.score, m_score);
    check_val("lives", bus.lives, m_lives);
    if (carry) bus.user_input = 6'b001000;
    tick();
    check_val("pulse_width", {bus.round_correct, bus.round_wrong, bus.timeout}, 0);
    repeat (FEEDBACK - 2) tick();
    check_val("fb_last_state", bus.state, 4);
    tick();
    nxt = (m_lives == 0) ? 5 : 1;
    check_val("after_fb_state", bus.state, nxt);
    check_val("dead_flag", bus.dead, (nxt == 5));
    if (carry && nxt == 1) begin
      check_val("carry_ready", bus.ins_ready, 0);
      bus.ins_valid = 1'b1;
      tick();
      check_val("carry_blocked", bus.state, 1);
      bus.ins_valid  = 1'b0;
      bus.user_input = '0;
      #1;
      check_val("release_ready", bus.ins_ready, 1);
    end
    bus.user_input = '0;
  endtask

  initial begin
    int tgt;
    int r;
    logic [N_CH-1:0] pv;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.user_input = '0;
    bus.ins_target = '0;
    bus.ins_invert = 1'b0;
    bus.ins_valid = 1'b0;
    m_score = 0;
    m_lives = LIVES;
    repeat (2) tick();
    check_val("rst_state", bus.state, 0);
    check_val("rst_score", bus.score, 0);
    check_val("rst_lives", bus.lives, LIVES);
    check_val("rst_ready", bus.ins_ready, 0);
    check_val("rst_pulses", {bus.round_correct, bus.round_wrong, bus.timeout}, 0);
    check_val("rst_dead", bus.dead, 0);
    reset = 1'b0;
    tick();
    check_val("idle_hold", bus.state, 0);
    do_start();

    play_round(2, 0, 6'b000100, 1, 3, 0);   // plain correct
    play_round(2, 1, 6'b010000, 2, 2, 0);   // inverted correct
    play_round(2, 1, 6'b000100, 0, 1, 0);   // inverted wrong
    play_round(0, 0, 6'b000000, 0, 0, 0);   // timeout -> dead
    do_start();
    play_round(3, 0, 6'b000000, 0, 0, 0);
    play_round(3, 0, 6'b000000, 0, 0, 0);   // second timeout -> dead
    do_start();
    for (int i = 0; i < 4; i++) play_round(i, 0, 6'(1 << i), 1, 2, 0);  // saturate
    play_round(1, 0, 6'b000110, 0, 2, 0);   // multi-key wrong
    play_round(5, 0, 6'b100000, 3, 2, 1);   // key carried into ARM
    play_round(0, 1, 6'b000010, 7, 2, 0);   // press on the last cycle
    play_round(7, 0, 6'b000001, 2, 1, 0);   // out-of-range target, plain
    do_start();
    play_round(6, 1, 6'b000001, 2, 1, 0);   // out-of-range target, inverted

    for (int n = 0; n < 40; n++) begin
      tgt = $urandom_range(0, 7);
      r = $urandom_range(0, 7);
      if (r == 0)      pv = '0;
      else if (r == 1) pv = 6'($urandom_range(1, 63));
      else             pv = 6'(1 << $urandom_range(0, N_CH - 1));
      play_round(tgt, 1'($urandom_range(0, 1)), pv, $urandom_range(0, TIMEOUT - 1),
                 $urandom_range(1, 4), ($urandom_range(0, 3) == 0));
      if (m_lives == 0) do_start();
    end

    // Reset in the middle of a held press
    play_round(1, 0, 6'b000010, 0, 1, 0);
    if (m_lives == 0) do_start();
    bus.ins_target = 3'd2;
    bus.ins_invert = 1'b0;
    bus.ins_valid  = 1'b1;
    tick();
    bus.ins_valid  = 1'b0;
    bus.user_input = 6'b000100;
    tick();
    check_val("pre_reset_state", bus.state, 3);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_state", bus.state, 0);
    check_val("async_rst_lives", bus.lives, LIVES);
    check_val("async_rst_score", bus.score, 0);
    bus.user_input = '0;
    tick();
    tick();
    check_val("rst_no_pulse", {bus.round_correct, bus.round_wrong, bus.timeout}, 0);
    check_val("rst_held_state", bus.state, 0);
    reset = 1'b0;
    tick();
    check_val("post_rst_state", bus.state, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
